// File: rtl/bcd_clock_counter.sv
// bcd_clock_counter: BCD hh:mm:ss time-of-day counter for the 7-segment clock.
// Counts on a 1 Hz enable, supports 24-hour or 12-hour (with pm flag) display,
// a run/pause gate, edge-detected minute/hour set buttons and a midnight pulse.
// A seconds tick that collides with a button edge is parked in `pend` and
// applied on the next edge-free cycle, so button presses never eat a second.
module bcd_clock_counter #(
  parameter int unsigned TWELVE_HOUR = 0
) (
  input  logic       clk,
  input  logic       res,
  input  logic       tick,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [3:0] DIG0,
  output logic [3:0] DIG1,
  output logic [3:0] DIG2,
  output logic [3:0] DIG3,
  output logic [3:0] DIG4,
  output logic [3:0] DIG5,
  output logic       pm,
  output logic       day_tick
);

  localparam bit         MODE12 = (TWELVE_HOUR != 0);
  // Hours reset to 12 in 12-hour mode (12 AM), 00 otherwise.
  localparam logic [3:0] RST_H1 = MODE12 ? 4'd1 : 4'd0;
  localparam logic [3:0] RST_H0 = MODE12 ? 4'd2 : 4'd0;

  logic inc_min_q;
  logic inc_hr_q;
  logic pend;

  logic min_edge;
  logic hr_edge;
  logic any_edge;
  logic tick_run;
  logic do_step;
  logic pend_nxt;

  logic [8:0] sec_inc;
  logic [8:0] min_inc;
  logic [8:0] hr_inc;
  logic       sec_carry;
  logic       min_carry;
  logic       min_adv;
  logic       hr_adv;
  logic       hr_flag;

  logic [3:0] s0_nxt, s1_nxt, m0_nxt, m1_nxt, h0_nxt, h1_nxt;
  logic       pm_nxt;
  logic       day_nxt;

  // Add one to a 00-59 BCD pair; returns {carry, tens, units}.
  function automatic logic [8:0] inc60(input logic [3:0] tens, input logic [3:0] units);
    if (units == 4'd9) begin
      if (tens == 4'd5) inc60 = {1'b1, 4'd0, 4'd0};
      else              inc60 = {1'b0, tens + 4'd1, 4'd0};
    end else begin
      inc60 = {1'b0, tens, units + 4'd1};
    end
  endfunction

  // Advance the hour pair; returns {flag, tens, units}. The flag marks the
  // 23->00 wrap in 24-hour mode and the 11->12 pm toggle in 12-hour mode.
  function automatic logic [8:0] next_hour(input logic [3:0] tens, input logic [3:0] units);
    if (MODE12) begin
      if (tens == 4'd1 && units == 4'd2)      next_hour = {1'b0, 4'd0, 4'd1};
      else if (tens == 4'd1 && units == 4'd1) next_hour = {1'b1, 4'd1, 4'd2};
      else if (units == 4'd9)                 next_hour = {1'b0, 4'd1, 4'd0};
      else                                    next_hour = {1'b0, tens, units + 4'd1};
    end else begin
      if (tens == 4'd2 && units == 4'd3)      next_hour = {1'b1, 4'd0, 4'd0};
      else if (units == 4'd9)                 next_hour = {1'b0, tens + 4'd1, 4'd0};
      else                                    next_hour = {1'b0, tens, units + 4'd1};
    end
  endfunction

  // Edge detection, tick/pend arbitration and next-time computation.
  always_comb begin
    min_edge = inc_min & ~inc_min_q;
    hr_edge  = inc_hr & ~inc_hr_q;
    any_edge = min_edge | hr_edge;
    tick_run = tick & run;
    // A count step only happens on a cycle without button edges; a parked
    // tick and a fresh tick on the same cycle merge into one step.
    do_step  = ~any_edge & (tick_run | pend);
    pend_nxt = any_edge ? (pend | tick_run) : 1'b0;

    sec_inc   = inc60(DIG1, DIG0);
    min_inc   = inc60(DIG3, DIG2);
    hr_inc    = next_hour(DIG5, DIG4);
    sec_carry = sec_inc[8];
    min_carry = min_inc[8];
    hr_flag   = hr_inc[8];

    // Button minute increments never carry into hours.
    min_adv = (do_step & sec_carry) | min_edge;
    hr_adv  = (do_step & sec_carry & min_carry) | hr_edge;

    s1_nxt = DIG1;
    s0_nxt = DIG0;
    m1_nxt = DIG3;
    m0_nxt = DIG2;
    h1_nxt = DIG5;
    h0_nxt = DIG4;
    pm_nxt = pm;

    if (do_step) begin
      s1_nxt = sec_inc[7:4];
      s0_nxt = sec_inc[3:0];
    end
    if (min_adv) begin
      m1_nxt = min_inc[7:4];
      m0_nxt = min_inc[3:0];
    end
    if (hr_adv) begin
      h1_nxt = hr_inc[7:4];
      h0_nxt = hr_inc[3:0];
      if (hr_flag) pm_nxt = ~pm;
    end
    if (!MODE12) pm_nxt = 1'b0;

    // Midnight comes only from the counting carry chain, never from inc_hr.
    if (MODE12) day_nxt = do_step & sec_carry & min_carry & hr_flag & pm;
    else        day_nxt = do_step & sec_carry & min_carry & hr_flag;
  end

  // Register the time, flags, edge-detect history and parked tick.
  always_ff @(posedge clk) begin
    if (!res) begin
      DIG0      <= 4'd0;
      DIG1      <= 4'd0;
      DIG2      <= 4'd0;
      DIG3      <= 4'd0;
      DIG4      <= RST_H0;
      DIG5      <= RST_H1;
      pm        <= 1'b0;
      day_tick  <= 1'b0;
      inc_min_q <= 1'b0;
      inc_hr_q  <= 1'b0;
      pend      <= 1'b0;
    end else begin
      DIG0      <= s0_nxt;
      DIG1      <= s1_nxt;
      DIG2      <= m0_nxt;
      DIG3      <= m1_nxt;
      DIG4      <= h0_nxt;
      DIG5      <= h1_nxt;
      pm        <= pm_nxt;
      day_tick  <= day_nxt;
      inc_min_q <= inc_min;
      inc_hr_q  <= inc_hr;
      pend      <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Testbench for bcd_clock_counter: a 24-hour and a 12-hour instance share the
// same stimulus. The driver pushes hand-computed expected displays tagged with
// the clock edge that should produce them; a monitor pops and compares.
module tb_bcd_clock_counter;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic tick = 1'b0;
  logic run = 1'b1;
  logic inc_min = 1'b0;
  logic inc_hr = 1'b0;

  logic [3:0] a0, a1, a2, a3, a4, a5;
  logic       a_pm, a_dt;
  logic [3:0] b0, b1, b2, b3, b4, b5;
  logic       b_pm, b_dt;

  // Entry layout: [58] instance (0 = 24 h, 1 = 12 h), [57:26] edge number,
  // [25:0] {day_tick, pm, h1, h0, m1, m0, s1, s0}.
  logic [58:0] exp_q[$];
  string       name_q[$];
  logic [31:0] cyc_cnt = 32'd0;
  int          checks = 0;
  int          failures = 0;

  bcd_clock_counter #(.TWELVE_HOUR(0)) dut24 (
    .clk(clk), .res(res), .tick(tick), .run(run),
    .inc_min(inc_min), .inc_hr(inc_hr),
    .DIG0(a0), .DIG1(a1), .DIG2(a2), .DIG3(a3), .DIG4(a4), .DIG5(a5),
    .pm(a_pm), .day_tick(a_dt)
  );

  bcd_clock_counter #(.TWELVE_HOUR(1)) dut12 (
    .clk(clk), .res(res), .tick(tick), .run(run),
    .inc_min(inc_min), .inc_hr(inc_hr),
    .DIG0(b0), .DIG1(b1), .DIG2(b2), .DIG3(b3), .DIG4(b4), .DIG5(b5),
    .pm(b_pm), .day_tick(b_dt)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout required finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [25:0] tv(input int hh, input int mm, input int ss,
                                     input logic p, input logic dt);
    tv = {dt, p, 4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
          4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Expect value v on instance sel right after the next driven edge.
  task automatic exp(input logic sel, input logic [25:0] v, input string nm);
    exp_q.push_back({sel, cyc_cnt + 32'd1, v});
    name_q.push_back(nm);
  endtask

  // Drive one cycle of inputs (called at a negedge).
  task automatic cyc(input logic t, input logic r, input logic m, input logic h);
    tick = t;
    run = r;
    inc_min = m;
    inc_hr = h;
    @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic press_hr(input int n);
    repeat (n) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Check both instances on an idle (no tick, no button) cycle.
  task automatic chk_idle(input logic [25:0] v24, input logic [25:0] v12,
                          input string nm, input logic r);
    exp(1'b0, v24, {nm, "_24"});
    exp(1'b1, v12, {nm, "_12"});
    cyc(1'b0, r, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    res = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    exp(1'b0, tv(0, 0, 0, 1'b0, 1'b0), "reset_24");
    exp(1'b1, tv(12, 0, 0, 1'b0, 1'b0), "reset_12");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    res = 1'b1;
  endtask

  // Monitor / scoreboard: compare every due entry just after each edge.
  initial begin
    logic [58:0] head;
    logic [25:0] act;
    string       nm;
    forever begin
      @(posedge clk);
      cyc_cnt = cyc_cnt + 32'd1;
      #1;
      while (exp_q.size() > 0) begin
        head = exp_q[0];
        if (head[57:26] > cyc_cnt) break;
        void'(exp_q.pop_front());
        nm = name_q.pop_front();
        act = head[58] ? {b_dt, b_pm, b5, b4, b3, b2, b1, b0}
                       : {a_dt, a_pm, a5, a4, a3, a2, a1, a0};
        checks++;
        if (head[57:26] != cyc_cnt) begin
          failures++;
          $display("FAIL %s: checked at edge %0d, required edge %0d", nm, cyc_cnt, head[57:26]);
        end else if (act !== head[25:0]) begin
          failures++;
          $display("FAIL %s: got {dt,pm,hhmmss}=%h required %h", nm, act, head[25:0]);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    @(negedge clk);
    do_reset();

    // 60 ticks from reset: one minute.
    tick_n(60);
    chk_idle(tv(0, 1, 0, 0, 0), tv(12, 1, 0, 0, 0), "sixty_ticks", 1'b1);

    // Reach 14:33:27, then reset with a tick present.
    press_hr(14);
    press_min(32);
    tick_n(27);
    chk_idle(tv(14, 33, 27, 0, 0), tv(2, 33, 27, 1, 0), "set_143327", 1'b1);
    res = 1'b0;
    exp(1'b0, tv(0, 0, 0, 0, 0), "reset_tick_24");
    exp(1'b1, tv(12, 0, 0, 0, 0), "reset_tick_12");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    res = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Midnight rollover: 23:59:58 (11:59:58 PM) + 2 ticks.
    press_hr(23);
    press_min(59);
    tick_n(58);
    chk_idle(tv(23, 59, 58, 0, 0), tv(11, 59, 58, 1, 0), "pre_midnight", 1'b1);
    exp(1'b0, tv(23, 59, 59, 0, 0), "tick_235959_24");
    exp(1'b1, tv(11, 59, 59, 1, 0), "tick_235959_12");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    exp(1'b0, tv(0, 0, 0, 0, 1), "midnight_24");
    exp(1'b1, tv(12, 0, 0, 0, 1), "midnight_12");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_idle(tv(0, 0, 0, 0, 0), tv(12, 0, 0, 0, 0), "day_tick_drop", 1'b1);

    // Noon: 11:59:59 AM + tick -> 12:00:00 PM, no day_tick.
    press_hr(11);
    press_min(59);
    tick_n(59);
    chk_idle(tv(11, 59, 59, 0, 0), tv(11, 59, 59, 0, 0), "pre_noon", 1'b1);
    exp(1'b0, tv(12, 0, 0, 0, 0), "noon_24");
    exp(1'b1, tv(12, 0, 0, 1, 0), "noon_12");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // Held inc_min at 10:59:30: exactly one step, no hour carry.
    do_reset();
    press_hr(10);
    press_min(59);
    tick_n(30);
    chk_idle(tv(10, 59, 30, 0, 0), tv(10, 59, 30, 0, 0), "pre_min_hold", 1'b1);
    exp(1'b0, tv(10, 0, 30, 0, 0), "min_wrap_24");
    exp(1'b1, tv(10, 0, 30, 0, 0), "min_wrap_12");
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (18) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    exp(1'b0, tv(10, 0, 30, 0, 0), "min_held_24");
    exp(1'b1, tv(10, 0, 30, 0, 0), "min_held_12");
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // inc_hr at 23:xx wraps without day_tick.
    press_hr(13);
    chk_idle(tv(23, 0, 30, 0, 0), tv(11, 0, 30, 1, 0), "pre_hr_wrap", 1'b1);
    exp(1'b0, tv(0, 0, 30, 0, 0), "hr_wrap_24");
    exp(1'b1, tv(12, 0, 30, 0, 0), "hr_wrap_12");
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Tick colliding with an inc_min edge at 08:15:59.
    do_reset();
    press_hr(8);
    press_min(15);
    tick_n(59);
    chk_idle(tv(8, 15, 59, 0, 0), tv(8, 15, 59, 0, 0), "pre_collide", 1'b1);
    exp(1'b0, tv(8, 16, 59, 0, 0), "collide_24");
    exp(1'b1, tv(8, 16, 59, 0, 0), "collide_12");
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    exp(1'b0, tv(8, 17, 0, 0, 0), "deferred_24");
    exp(1'b1, tv(8, 17, 0, 0, 0), "deferred_12");
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Both button edges in one cycle.
    exp(1'b0, tv(9, 18, 0, 0, 0), "both_edges_24");
    exp(1'b1, tv(9, 18, 0, 0, 0), "both_edges_12");
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Parked tick merged with a fresh tick on the next cycle: one step.
    exp(1'b0, tv(9, 19, 0, 0, 0), "park_24");
    exp(1'b1, tv(9, 19, 0, 0, 0), "park_12");
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    exp(1'b0, tv(9, 19, 1, 0, 0), "merge_24");
    exp(1'b1, tv(9, 19, 1, 0, 0), "merge_12");
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_idle(tv(9, 19, 1, 0, 0), tv(9, 19, 1, 0, 0), "merge_hold", 1'b1);

    // Paused: ticks ignored, inc_hr still works, tick+edge sets no pend.
    repeat (5) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk_idle(tv(9, 19, 1, 0, 0), tv(9, 19, 1, 0, 0), "paused", 1'b0);
    exp(1'b0, tv(10, 19, 1, 0, 0), "hr_paused_24");
    exp(1'b1, tv(10, 19, 1, 0, 0), "hr_paused_12");
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp(1'b0, tv(11, 19, 1, 0, 0), "hr_tick_paused_24");
    exp(1'b1, tv(11, 19, 1, 0, 0), "hr_tick_paused_12");
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk_idle(tv(11, 19, 1, 0, 0), tv(11, 19, 1, 0, 0), "no_pend_paused", 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Resume: only ticks seen with run=1 count.
    tick_n(3);
    chk_idle(tv(11, 19, 4, 0, 0), tv(11, 19, 4, 0, 0), "resumed", 1'b1);

    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_clock_counter.md
# bcd_clock_counter

Parametrised BCD time-of-day counter (hh:mm:ss) for the 7-segment clock, successor to the fixed 24-hour hours counter. Adds a compile-time 12/24-hour mode with AM/PM flag, a run/pause gate, edge-detected minute and hour set buttons that never corrupt a concurrent seconds tick, and a day-rollover pulse for a future calendar block. Sits between the 1 Hz tick generator and the 7-segment multiplexer.

## Interface
- `TWELVE_HOUR`, 0: 0 = 24-hour (00–23), 1 = 12-hour (12, 01–11) with `pm` flag.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `res`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `tick`  in  1  one-cycle enable, one per second; synchronous to `clk`.
- `run`  in  1  1 = count on `tick`; 0 = `tick` ignored (set buttons still work).
- `inc_min`  in  1  level from debounced/synchronised button; each rising edge adds one minute.
- `inc_hr`  in  1  level from debounced/synchronised button; each rising edge adds one hour.
- `DIG0`  out  4  seconds units, BCD 0–9.
- `DIG1`  out  4  seconds tens, BCD 0–5.
- `DIG2`  out  4  minutes units, BCD 0–9.
- `DIG3`  out  4  minutes tens, BCD 0–5.
- `DIG4`  out  4  hours units, BCD.
- `DIG5`  out  4  hours tens, BCD 0–2 (24 h) or 0–1 (12 h).
- `pm`  out  1  12-hour mode only: 1 = PM. Tied 0 when `TWELVE_HOUR`=0.
- `day_tick`  out  1  one-cycle pulse on midnight rollover.

## Operation
- All outputs registered. Reset (`res`=0 at a clock edge) forces:
  - 24 h: 00:00:00.
  - 12 h: 12:00:00, `pm`=0.
  - `day_tick`=0, and both edge-detect registers cleared to 0.
  - Reset has priority over every other input.
- Edge detection: `inc_min_q`/`inc_hr_q` hold the previous cycle's level. An edge is `inc_x`=1 and `inc_x_q`=0. A held button gives exactly one increment.
- Count step (effective tick; see pending rule): seconds +1 in BCD.
  - 59 s → 00 and carry to minutes.
  - 59 min → 00 and carry to hours.
- Hours advance:
  - 24 h: 23 → 00 wraps, with `day_tick`.
  - 12 h sequence: 12 → 01 → … → 11 → 12. The 11 → 12 step toggles `pm`.
  - `day_tick` fires when `pm` goes 1 → 0, i.e. 11:59:59 PM → 12:00:00 AM.
- `inc_min` edge: minutes +1, 59 → 00 with no carry into hours. Seconds untouched.
- `inc_hr` edge: hours +1 with the same wrap and `pm` toggle rules. Never asserts `day_tick`. Minutes and seconds untouched.
- Both edges in the same cycle: both applied independently in that cycle.
- Pending rule:
  - A tick with `run`=1 in a cycle carrying any button edge sets a 1-bit `pend` instead of counting.
  - `pend` is consumed on the next cycle with no button edge, as one count step.
  - A tick arriving while `pend`=1 with no edge is merged, so the two are not counted twice. Upstream guarantees `tick` spacing ≫ 2 cycles.
  - Reset clears `pend`.
- `run`=0: `tick` is ignored and does not set `pend`. An already-set `pend` is still consumed.
- Digits never hold non-BCD or out-of-range values. No illegal state is reachable from reset.

## Timing
- Latency: an input sampled at edge N becomes visible on the outputs after edge N (1 cycle, registered).
- A deferred tick appears at edge N+1, or later if button edges repeat every cycle.
- `day_tick` is high for exactly the one cycle in which the outputs show the post-rollover time.
- A reset in the middle of a carry chain (e.g. at 23:59:59 with a tick present) gives the reset values with `day_tick`=0.
- Button edges must be separated by at least 2 cycles to be counted individually. This is guaranteed by the debouncer.

## Test plan
- Reset then 60 ticks (24 h) → 00:01:00. Reset at 14:33:27 with `tick`=1 → 00:00:00 next cycle, `day_tick`=0.
- 24 h, preload 23:59:58, 2 ticks → 23:59:59, then 00:00:00 with a 1-cycle `day_tick`.
- 12 h, preload 11:59:59 AM, tick → 12:00:00 `pm`=1, `day_tick`=0. From 11:59:59 PM, tick → 12:00:00 `pm`=0, `day_tick`=1.
- `inc_min` held high 20 cycles at 10:59:30 → 10:00:30, exactly one step, no hour carry. `inc_hr` at 23:xx (24 h) → 00:xx, `day_tick`=0.
- `tick` and `inc_min` edge in the same cycle at 08:15:59 → 08:16:59 next cycle, then 08:17:00 one cycle later.
- `run`=0 with 5 ticks → time frozen. `inc_hr` while paused → hours +1. `run`=1 → counting resumes with no lost or extra seconds beyond ticks seen while `run`=1.
